csr_unit: RTL
=============

Name: csr_unit

Overview:
- Machine-mode CSR file and trap controller for the 5-stage RISC-V pipeline.
- Consumes the CSR access fields from the execute stage (Zicsr ops), and retirement/trap events from writeback.
- Returns the old CSR value for writeback, plus a PC redirect to fetch on trap entry or MRET.
- Holds `mstatus`, `mtvec`, `mscratch`, `mepc`, `mcause`, `mhartid` and, optionally, the 64-bit `mcycle`/`minstret` counters.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of `mtvec` (bits [1:0] forced 0).
- HART_ID, 0, value returned by `mhartid` (0xF14).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- csr_en  in  1  valid CSR instruction in execute this cycle
- csr_funct3  in  3  001 RW, 010 RS, 011 RC; 101/110/111 are the immediate forms, same semantics
- csr_addr  in  12  CSR address (`InstrE[31:20]`)
- csr_wdata  in  32  operand: forwarded rs1, or zero-extended zimm
- csr_src_zero  in  1  rs1 field / zimm == 0; suppresses the write for RS/RC
- csr_rdata  out  32  old CSR value (combinational from current state)
- csr_illegal  out  1  unsupported address, or write to a read-only CSR
- instr_retire  in  1  one instruction retired this cycle (writeback valid, not flushed)
- trap_req  in  1  take a trap this cycle
- trap_cause  in  32  value for `mcause`
- trap_pc  in  32  PC of the faulting instruction, written to `mepc`
- mret_req  in  1  MRET in execute
- redirect_valid  out  1  `trap_req | mret_req`
- redirect_pc  out  32  `mtvec` if `trap_req`, else `mepc`

Behaviour:

Reset (`rst` high at a clk edge):
- `mstatus.MIE = 0`, `mstatus.MPIE = 0`.
- `mtvec = RESET_MTVEC & ~3`.
- `mscratch`, `mepc`, `mcause` = 0.
- Counters = 0.
- Reset overrides every other input in that cycle. Outputs are combinational, so after reset `csr_rdata` reflects the reset values and `redirect_valid` = 0 while the request inputs are low.

Register fields:
- `mstatus` reads `{19'b0, MPP=2'b11, 3'b0, MPIE, 3'b0, MIE, 3'b0}`; only MIE (bit 3) and MPIE (bit 7) are writable.
- `mepc[1:0]` and `mtvec[1:0]` are always 0 (direct mode).

Write value and timing:
- RW: `new = wdata`. RS: `new = old | wdata`. RC: `new = old & ~wdata`.
- The write commits at the next clk edge; `csr_rdata` shows the old value during the access cycle.
- No write occurs when:
  - RS/RC with `csr_src_zero = 1` (reads are still performed);
  - `csr_en = 0`;
  - `csr_illegal = 1`.

Illegal accesses:
- `csr_illegal = csr_en & (address unimplemented | (addr == 0xF14 & write would occur))`.
- An illegal access returns `csr_rdata` = 0 and changes no state.

Counters:
- `mcycle` increments every non-reset cycle.
- `minstret` increments when `instr_retire` = 1.
- Both are 64-bit and wrap from 2^64-1 to 0.
- Access: 0xB00/0xB80 read/write the low/high half of `mcycle`; 0xB02/0xB82 the low/high half of `minstret`. A half-write leaves the other half unchanged.
- A CSR write to a counter half in the same cycle as its increment: the written value wins and no increment is applied that cycle.

Trap entry (`trap_req`):
- `mepc <= trap_pc & ~3`.
- `mcause <= trap_cause`.
- `MPIE <= MIE`, `MIE <= 0`.
- `redirect_pc = mtvec`.

MRET (`mret_req` without `trap_req`):
- `MIE <= MPIE`, `MPIE <= 1`.
- `redirect_pc = mepc`.

Priority in the same cycle: `rst` > `trap_req` > `mret_req` > CSR write.
- When a trap or MRET is taken, a simultaneous CSR write is discarded.
- Counters still advance during a trap cycle.

Optional Feature:
- Macro: `CSR_COUNTERS_EN`.
- Defined: `mcycle`/`mcycleh`/`minstret`/`minstreth` are implemented as described above.
- Undefined:
  - No counter flops are present.
  - Addresses 0xB00/0xB02/0xB80/0xB82 are treated as unimplemented: `csr_illegal` = 1, `csr_rdata` = 0.
  - `instr_retire` is ignored.

Test Plan:
- Reset, then CSRRW 0x340 with wdata `32'hDEADBEEF` → `csr_rdata` = 0 that cycle. Next-cycle read of 0x340 → `32'hDEADBEEF`.
- `mscratch = 32'hF0F0_0000`:
  - CSRRS 0x340, wdata `32'h0000_00FF` → `32'hF0F0_00FF`.
  - Then CSRRC, wdata `32'hF000_0000` → `32'h00F0_00FF`.
  - RS with `csr_src_zero` = 1 → value unchanged.
- `mtvec = 32'h100`, `MIE = 1`, `trap_req` with cause 11 and `trap_pc = 32'h2A`:
  - Same cycle: `redirect_pc = 32'h100`.
  - Next cycle: `mepc = 32'h28`, `mcause = 11`, `mstatus` reads `32'h1880`.
- Then `mret_req` → `redirect_pc = 32'h28`; after the edge `mstatus` reads `32'h1888`.
- `trap_req`, `mret_req` and CSRRW 0x340 asserted together → trap redirect is taken and `mscratch` is unchanged.
- `CSR_COUNTERS_EN` defined:
  - Write `mcycle` low = `32'hFFFF_FFFE`, high = `32'hFFFF_FFFF` → wraps to 0 two cycles later.
  - 5 `instr_retire` pulses → `minstret` = 5.
- `CSR_COUNTERS_EN` undefined: read 0xB00 → `csr_illegal` = 1, `csr_rdata` = 0.
- Write 0xF14 → `csr_illegal` = 1, no state change. Read 0x7C0 → `csr_illegal` = 1.

Source files
------------

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap controller for the 5-stage RISC-V pipeline.
// Holds mstatus (MIE/MPIE), mtvec, mscratch, mepc, mcause and mhartid; returns the
// old CSR value combinationally and commits Zicsr writes at the next clock edge.
// Trap entry and MRET produce a PC redirect and update mstatus/mepc/mcause.
// Optional feature macro: CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters
// (0xB00/0xB80/0xB02/0xB82). Without it those addresses are unimplemented.
module csr_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_src_zero,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

    // Architectural state; low two bits of mtvec/mepc are hardwired zero so not stored.
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:2] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:2] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`endif

    logic [31:0] mstatus_val;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        addr_impl;
    logic        write_op;
    logic        do_write;

    // funct3[2] only selects register vs immediate operand, which arrives pre-muxed.
    logic unused_sigs;
`ifdef CSR_COUNTERS_EN
    assign unused_sigs = ^{csr_funct3[2], trap_pc[1:0]};
`else
    assign unused_sigs = ^{csr_funct3[2], trap_pc[1:0], instr_retire};
`endif

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    // Address decode, read mux, illegal detection and write-value computation.
    always_comb begin
        addr_impl = 1'b1;
        old_val   = 32'd0;
        case (csr_addr)
            ADDR_MSTATUS:   old_val = mstatus_val;
            ADDR_MTVEC:     old_val = {mtvec_q, 2'b00};
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = {mepc_q, 2'b00};
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MHARTID:   old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    old_val = mcycle_q[31:0];
            ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
            ADDR_MINSTRET:  old_val = minstret_q[31:0];
            ADDR_MINSTRETH: old_val = minstret_q[63:32];
`endif
            default:        addr_impl = 1'b0;
        endcase

        // RW always writes; RS/RC write only when the source operand is nonzero.
        write_op = csr_en & ((csr_funct3[1:0] == 2'b01) |
                             ((csr_funct3[1:0] == 2'b10 || csr_funct3[1:0] == 2'b11) & ~csr_src_zero));

        csr_illegal = csr_en & (~addr_impl | ((csr_addr == ADDR_MHARTID) & write_op));
        csr_rdata   = csr_illegal ? 32'd0 : old_val;

        case (csr_funct3[1:0])
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase

        // Trap and MRET both discard a simultaneous CSR write.
        do_write = write_op & ~csr_illegal & ~trap_req & ~mret_req;
    end

    // Redirect to fetch: trap vector has priority over the MRET return address.
    always_comb begin
        redirect_valid = trap_req | mret_req;
        redirect_pc    = trap_req ? {mtvec_q, 2'b00} : {mepc_q, 2'b00};
    end

    // Next-state: trap > MRET > CSR write; counters advance independently.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = instr_retire ? (minstret_q + 64'd1) : minstret_q;
`endif
        if (trap_req) begin
            mepc_d   = trap_pc[31:2];
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_req) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                ADDR_MTVEC:     mtvec_d    = new_val[31:2];
                ADDR_MSCRATCH:  mscratch_d = new_val;
                ADDR_MEPC:      mepc_d     = new_val[31:2];
                ADDR_MCAUSE:    mcause_d   = new_val;
`ifdef CSR_COUNTERS_EN
                // A written half replaces the increment for that cycle.
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
                ADDR_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
                ADDR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
`endif
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC[31:2];
            mscratch_q <= 32'd0;
            mepc_q     <= 30'd0;
            mcause_q   <= 32'd0;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
`endif
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end

endmodule
